// File: rtl/xor_resp_checker.sv
// Checks a device's XOR result against A^B delayed by LATENCY cycles, and counts checks and mismatches.
// Optional feature macro: XOR_CHK_CAPTURE_EN adds first-mismatch capture outputs o__first_exp/o__first_act.
module xor_resp_checker #(
    parameter int DATA_WIDTH = 10,
    parameter int LATENCY    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i__clk,
    input  logic                  i__areset_n,
    input  logic                  i__sreset_n,
    input  logic                  i__en,
    input  logic [DATA_WIDTH-1:0] i__inA,
    input  logic [DATA_WIDTH-1:0] i__inB,
    input  logic [DATA_WIDTH-1:0] i__dout,
    output logic                  o__mismatch,
    output logic [CNT_WIDTH-1:0]  o__chk_cnt,
    output logic [CNT_WIDTH-1:0]  o__err_cnt,
    output logic                  o__busy,
`ifdef XOR_CHK_CAPTURE_EN
    output logic [1:0]            o__state,
    output logic [DATA_WIDTH-1:0] o__first_exp,
    output logic [DATA_WIDTH-1:0] o__first_act
`else
    output logic [1:0]            o__state
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FAIL = 2'b10
    } state_t;

    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [DATA_WIDTH-1:0] exp_q [LATENCY];
    logic [DATA_WIDTH-1:0] exp_d [LATENCY];
    logic                  mismatch_q, mismatch_d;
    logic [CNT_WIDTH-1:0]  chk_cnt_q, chk_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    state_t                state_q, state_d;
    logic                  cmp_vld;
    logic                  cmp_fail;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Oldest delay-line entry is compared against the current result.
    assign cmp_vld  = vld_q[LATENCY-1];
    assign cmp_fail = cmp_vld && (exp_q[LATENCY-1] != i__dout);

    always_comb begin
        exp_d[0] = i__inA ^ i__inB;
        for (int i = 1; i < LATENCY; i++) begin
            exp_d[i] = exp_q[i-1];
        end
    end

    always_comb begin
        vld_d      = '0;
        vld_d[0]   = i__en;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        chk_cnt_d  = cmp_vld  ? sat_inc(chk_cnt_q) : chk_cnt_q;
        err_cnt_d  = cmp_fail ? sat_inc(err_cnt_q) : err_cnt_q;
        mismatch_d = cmp_fail;
        // Synchronous clear drops in-flight samples, so their compare never happens.
        if (!i__sreset_n) begin
            vld_d      = '0;
            chk_cnt_d  = '0;
            err_cnt_d  = '0;
            mismatch_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i__sreset_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (i__en)    state_d = ST_RUN;
                ST_RUN:  if (cmp_fail) state_d = ST_FAIL;
                ST_FAIL:               state_d = ST_FAIL;
                default:               state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i__clk or negedge i__areset_n) begin
        if (!i__areset_n) begin
            vld_q      <= '0;
            chk_cnt_q  <= '0;
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            vld_q      <= vld_d;
            chk_cnt_q  <= chk_cnt_d;
            err_cnt_q  <= err_cnt_d;
            mismatch_q <= mismatch_d;
            state_q    <= state_d;
        end
    end

    // Expected values are qualified by vld_q, so they need no reset.
    always_ff @(posedge i__clk) begin
        exp_q <= exp_d;
    end

    always_comb begin
        o__state    = state_q;
        o__mismatch = mismatch_q;
        o__chk_cnt  = chk_cnt_q;
        o__err_cnt  = err_cnt_q;
        o__busy     = |vld_q;
    end

`ifdef XOR_CHK_CAPTURE_EN
    logic [DATA_WIDTH-1:0] first_exp_q, first_exp_d;
    logic [DATA_WIDTH-1:0] first_act_q, first_act_d;

    // The first mismatch after reset is the one that moves RUN into FAIL.
    always_comb begin
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        if (!i__sreset_n) begin
            first_exp_d = '0;
            first_act_d = '0;
        end else if (cmp_fail && (state_q != ST_FAIL)) begin
            first_exp_d = exp_q[LATENCY-1];
            first_act_d = i__dout;
        end
    end

    always_ff @(posedge i__clk or negedge i__areset_n) begin
        if (!i__areset_n) begin
            first_exp_q <= '0;
            first_act_q <= '0;
        end else begin
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
        end
    end

    assign o__first_exp = first_exp_q;
    assign o__first_act = first_act_q;
`else
`endif

endmodule

// File: tb/tb_xor_resp_checker.sv
// Scoreboard bench for xor_resp_checker: three instances (LATENCY 1/2/3, one with CNT_WIDTH=4).
// Capture outputs are connected and checked when XOR_CHK_CAPTURE_EN is defined.
module tb_xor_resp_checker;

    localparam int DW      = 10;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_FL   = 2;

    logic          clk = 1'b0;
    logic          areset_n;
    logic          sreset_n;
    logic [2:0]    en;
    logic [DW-1:0] a [3];
    logic [DW-1:0] b [3];
    logic [DW-1:0] d [3];
    logic [2:0]    mm;
    logic [2:0]    busy;
    logic [1:0]    st0, st1, st2;
    logic [15:0]   chk0, err0, chk2, err2;
    logic [3:0]    chk1, err1;
`ifdef XOR_CHK_CAPTURE_EN
    logic [DW-1:0] fe0, fa0, fe1, fa1, fe2, fa2;
`endif

    always #5 clk = ~clk;

    xor_resp_checker #(.DATA_WIDTH(DW), .LATENCY(1), .CNT_WIDTH(16)) u_dut_l1 (
        .i__clk(clk), .i__areset_n(areset_n), .i__sreset_n(sreset_n), .i__en(en[0]),
        .i__inA(a[0]), .i__inB(b[0]), .i__dout(d[0]),
        .o__mismatch(mm[0]), .o__chk_cnt(chk0), .o__err_cnt(err0), .o__busy(busy[0]),
`ifdef XOR_CHK_CAPTURE_EN
        .o__first_exp(fe0), .o__first_act(fa0),
`endif
        .o__state(st0)
    );

    xor_resp_checker #(.DATA_WIDTH(DW), .LATENCY(2), .CNT_WIDTH(4)) u_dut_l2 (
        .i__clk(clk), .i__areset_n(areset_n), .i__sreset_n(sreset_n), .i__en(en[1]),
        .i__inA(a[1]), .i__inB(b[1]), .i__dout(d[1]),
        .o__mismatch(mm[1]), .o__chk_cnt(chk1), .o__err_cnt(err1), .o__busy(busy[1]),
`ifdef XOR_CHK_CAPTURE_EN
        .o__first_exp(fe1), .o__first_act(fa1),
`endif
        .o__state(st1)
    );

    xor_resp_checker #(.DATA_WIDTH(DW), .LATENCY(3), .CNT_WIDTH(16)) u_dut_l3 (
        .i__clk(clk), .i__areset_n(areset_n), .i__sreset_n(sreset_n), .i__en(en[2]),
        .i__inA(a[2]), .i__inB(b[2]), .i__dout(d[2]),
        .o__mismatch(mm[2]), .o__chk_cnt(chk2), .o__err_cnt(err2), .o__busy(busy[2]),
`ifdef XOR_CHK_CAPTURE_EN
        .o__first_exp(fe2), .o__first_act(fa2),
`endif
        .o__state(st2)
    );

    typedef struct {
        int    cyc;
        int    inst;
        string name;
        int    mm;
        int    chk;
        int    err;
        int    busy;
        int    st;
        int    fexp;
        int    fact;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic sb_push(input int c, input int inst, input string nm, input int m,
                           input int ck, input int er, input int bz, input int s,
                           input int fe, input int fa);
        exp_t e;
        int   idx;
        e.cyc = c; e.inst = inst; e.name = nm; e.mm = m; e.chk = ck; e.err = er;
        e.busy = bz; e.st = s; e.fexp = fe; e.fact = fa;
        idx = sbq.size();
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sbq.insert(idx, e);
    endtask

    task automatic push_reset_all(input int c, input string nm);
        for (int i = 0; i < 3; i++) sb_push(c, i, nm, 0, 0, 0, 0, ST_IDLE, 0, 0);
    endtask

    // Monitor: pops every expectation scheduled for this cycle and compares it.
    always @(negedge clk) begin
        exp_t e;
        int   a_mm, a_chk, a_err, a_bz, a_st, a_fe, a_fa;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            a_fe = 0;
            a_fa = 0;
            case (e.inst)
                0: begin
                    a_mm = {31'd0, mm[0]}; a_bz = {31'd0, busy[0]}; a_st = {30'd0, st0};
                    a_chk = {16'd0, chk0}; a_err = {16'd0, err0};
`ifdef XOR_CHK_CAPTURE_EN
                    a_fe = {22'd0, fe0}; a_fa = {22'd0, fa0};
`endif
                end
                1: begin
                    a_mm = {31'd0, mm[1]}; a_bz = {31'd0, busy[1]}; a_st = {30'd0, st1};
                    a_chk = {28'd0, chk1}; a_err = {28'd0, err1};
`ifdef XOR_CHK_CAPTURE_EN
                    a_fe = {22'd0, fe1}; a_fa = {22'd0, fa1};
`endif
                end
                default: begin
                    a_mm = {31'd0, mm[2]}; a_bz = {31'd0, busy[2]}; a_st = {30'd0, st2};
                    a_chk = {16'd0, chk2}; a_err = {16'd0, err2};
`ifdef XOR_CHK_CAPTURE_EN
                    a_fe = {22'd0, fe2}; a_fa = {22'd0, fa2};
`endif
                end
            endcase
            if (e.cyc < cyc) begin
                cmp($sformatf("%s.i%0d.missed_cycle", e.name, e.inst), cyc, e.cyc);
            end else begin
                cmp($sformatf("%s.i%0d.mismatch", e.name, e.inst), a_mm, e.mm);
                cmp($sformatf("%s.i%0d.chk_cnt", e.name, e.inst), a_chk, e.chk);
                cmp($sformatf("%s.i%0d.err_cnt", e.name, e.inst), a_err, e.err);
                cmp($sformatf("%s.i%0d.busy", e.name, e.inst), a_bz, e.busy);
                cmp($sformatf("%s.i%0d.state", e.name, e.inst), a_st, e.st);
`ifdef XOR_CHK_CAPTURE_EN
                cmp($sformatf("%s.i%0d.first_exp", e.name, e.inst), a_fe, e.fexp);
                cmp($sformatf("%s.i%0d.first_act", e.name, e.inst), a_fa, e.fact);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input logic e, input logic [DW-1:0] av,
                       input logic [DW-1:0] bv, input logic [DW-1:0] dv);
        en[i] = e;
        a[i]  = av;
        b[i]  = bv;
        d[i]  = dv;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) drv(i, 1'b0, '0, '0, '0);
    endtask

    int t;

    initial begin
        areset_n = 1'b0;
        sreset_n = 1'b1;
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        areset_n = 1'b1;
        push_reset_all(cyc, "reset");
        tick();

        // LATENCY=1: matching compare, then a single-bit mismatch.
        t = cyc;
        drv(0, 1'b1, 10'h155, 10'h0AA, 10'h000);
        sb_push(t+1, 0, "l1_pre", 0, 0, 0, 1, ST_RUN, 0, 0);
        tick(); drv(0, 1'b0, 10'h000, 10'h000, 10'h1FF);
        sb_push(t+2, 0, "l1_match", 0, 1, 0, 0, ST_RUN, 0, 0);
        tick(); drv(0, 1'b1, 10'h0F0, 10'h00F, 10'h3FF);
        tick(); drv(0, 1'b0, 10'h000, 10'h000, 10'h0FE);
        sb_push(t+4, 0, "l1_miss", 1, 2, 1, 0, ST_FL, 255, 254);
        sb_push(t+5, 0, "l1_pulse_end", 0, 2, 1, 0, ST_FL, 255, 254);
        tick(); drv(0, 1'b0, 10'h000, 10'h000, 10'h000);
        tick(); tick();

        // LATENCY=3: mismatch enters FAIL, checking continues in FAIL.
        t = cyc;
        drv(2, 1'b1, 10'h3FF, 10'h001, 10'h000);
        sb_push(t+1, 2, "l3_pre", 0, 0, 0, 1, ST_RUN, 0, 0);
        tick(); drv(2, 1'b0, 10'h000, 10'h000, 10'h3FE);
        tick(); drv(2, 1'b0, 10'h000, 10'h000, 10'h3FE);
        sb_push(t+3, 2, "l3_wait", 0, 0, 0, 1, ST_RUN, 0, 0);
        tick(); drv(2, 1'b0, 10'h000, 10'h000, 10'h3FF);
        sb_push(t+4, 2, "l3_miss", 1, 1, 1, 0, ST_FL, 1022, 1023);
        tick(); drv(2, 1'b1, 10'h000, 10'h005, 10'h000);
        sb_push(t+5, 2, "l3_sticky", 0, 1, 1, 1, ST_FL, 1022, 1023);
        tick(); drv(2, 1'b0, 10'h000, 10'h000, 10'h000);
        tick(); tick();
        sb_push(t+8, 2, "l3_miss2", 1, 2, 2, 0, ST_FL, 1022, 1023);
        tick(); tick();

        // LATENCY=2: en pattern 1,0,1; dout in the bubble slot must be ignored.
        t = cyc;
        drv(1, 1'b1, 10'h00F, 10'h0F0, 10'h000);
        sb_push(t, 1, "l2_idle", 0, 0, 0, 0, ST_IDLE, 0, 0);
        sb_push(t+1, 1, "l2_b1", 0, 0, 0, 1, ST_RUN, 0, 0);
        tick(); drv(1, 1'b0, 10'h3FF, 10'h000, 10'h000);
        sb_push(t+2, 1, "l2_b2", 0, 0, 0, 1, ST_RUN, 0, 0);
        tick(); drv(1, 1'b1, 10'h123, 10'h321, 10'h0FF);
        sb_push(t+3, 1, "l2_cmp1", 0, 1, 0, 1, ST_RUN, 0, 0);
        tick(); drv(1, 1'b0, 10'h000, 10'h000, 10'h155);
        sb_push(t+4, 1, "l2_bubble", 0, 1, 0, 1, ST_RUN, 0, 0);
        tick(); drv(1, 1'b0, 10'h000, 10'h000, 10'h202);
        sb_push(t+5, 1, "l2_cmp2", 0, 2, 0, 0, ST_RUN, 0, 0);
        sb_push(t+6, 1, "l2_hold", 0, 2, 0, 0, ST_RUN, 0, 0);
        tick(); drv(1, 1'b0, 10'h000, 10'h000, 10'h000);
        tick(); tick();

        // Synchronous clear with two samples in flight.
        t = cyc;
        drv(1, 1'b1, 10'h001, 10'h002, 10'h000);
        tick(); drv(1, 1'b1, 10'h004, 10'h008, 10'h3FF);
        tick(); drv(1, 1'b1, 10'h3FF, 10'h000, 10'h3FF);
        sreset_n = 1'b0;
        sb_push(t+2, 1, "srst_pre", 0, 2, 0, 1, ST_RUN, 0, 0);
        push_reset_all(t+3, "srst");
        tick(); drv(1, 1'b0, 10'h000, 10'h000, 10'h3FF);
        sreset_n = 1'b1;
        sb_push(t+4, 1, "srst_after", 0, 0, 0, 0, ST_IDLE, 0, 0);
        tick(); idle_all();
        tick();

        // CNT_WIDTH=4: 20 consecutive mismatches saturate both counters at 15.
        t = cyc;
        sb_push(t+3, 1, "sat_first", 1, 1, 1, 1, ST_FL, 256, 0);
        sb_push(t+17, 1, "sat_15", 1, 15, 15, 1, ST_FL, 256, 0);
        sb_push(t+18, 1, "sat_hold", 1, 15, 15, 1, ST_FL, 256, 0);
        sb_push(t+22, 1, "sat_last", 1, 15, 15, 0, ST_FL, 256, 0);
        sb_push(t+23, 1, "sat_end", 0, 15, 15, 0, ST_FL, 256, 0);
        for (int k = 0; k < 24; k++) begin
            drv(1, (k < 20), 10'h100, 10'h000, 10'h000);
            tick();
        end
        idle_all();
        tick();

        // Asynchronous reset asserted between clock edges mid-stream.
        t = cyc;
        drv(0, 1'b1, 10'h001, 10'h002, 10'h000);
        tick(); drv(0, 1'b1, 10'h005, 10'h000, 10'h003);
        tick(); drv(0, 1'b1, 10'h007, 10'h000, 10'h005);
        sb_push(t+2, 0, "arst_pre", 0, 1, 0, 1, ST_RUN, 0, 0);
        tick(); drv(0, 1'b1, 10'h000, 10'h000, 10'h007);
        #2;
        areset_n = 1'b0;
        push_reset_all(t+3, "arst_mid");
        tick(); drv(0, 1'b0, 10'h000, 10'h000, 10'h000);
        push_reset_all(t+4, "arst_held");
        areset_n = 1'b1;
        push_reset_all(t+5, "arst_rel");
        tick(); tick(); tick();

        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s.i%0d.unchecked: actual=pending required=checked at cycle %0d",
                     e.name, e.inst, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xor_resp_checker.md
XOR_RESP_CHECKER -- requirements
Module: xor_resp_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 10: width of operands and result.
REQ-002 Parameter LATENCY, default 1, legal 1..8: cycles from operand sample to expected i__dout.
REQ-003 Parameter CNT_WIDTH, default 16: width of the check and error counters.
REQ-004 i__clk  input  1  sole clock; all logic on its rising edge.
REQ-005 i__areset_n  input  1  asynchronous active-low reset.
REQ-006 i__sreset_n  input  1  synchronous active-low clear.
REQ-007 i__en  input  1  operand-valid strobe; operands are sampled when high.
REQ-008 i__inA  input  DATA_WIDTH  operand A.
REQ-009 i__inB  input  DATA_WIDTH  operand B.
REQ-010 i__dout  input  DATA_WIDTH  result under check.
REQ-011 o__mismatch  output  1  one-cycle pulse per failed comparison.
REQ-012 o__chk_cnt  output  CNT_WIDTH  comparisons performed, saturating.
REQ-013 o__err_cnt  output  CNT_WIDTH  failed comparisons, saturating.
REQ-014 o__busy  output  1  high while any sample is in flight.
REQ-015 o__state  output  2  FSM state: 00 IDLE, 01 RUN, 10 FAIL.

Function
REQ-016 Each cycle, a LATENCY-deep delay line shifts in {i__en, i__inA ^ i__inB}; bubbles (i__en=0) are carried as invalid entries.
REQ-017 A sample taken at cycle t is compared against i__dout at cycle t+LATENCY, only if its entry is valid.
REQ-018 Comparison result is registered: o__mismatch is high at t+LATENCY+1 iff expected != i__dout, in all bit positions, no masking.
REQ-019 o__chk_cnt increments by 1 per comparison; o__err_cnt increments by 1 per mismatch; both hold at all-ones (no wrap).
REQ-020 o__busy = OR of the delay-line valid bits.
REQ-021 FSM transitions: IDLE->RUN on the first cycle i__en=1; RUN->FAIL on a mismatch; FAIL is sticky until reset; RUN never returns to IDLE.
REQ-022 Checking and counting continue unchanged in FAIL.
REQ-023 Back-to-back i__en=1 sustains one comparison per cycle with no stalls.

Reset
REQ-024 i__areset_n low clears immediately: delay line invalid, counters 0, o__mismatch 0, o__busy 0, o__state IDLE.
REQ-025 i__sreset_n low at a clock edge produces the same values as REQ-024 at that edge; in-flight samples are discarded, not compared.
REQ-026 i__areset_n dominates i__sreset_n; i__en sampled in a cycle with i__sreset_n low is ignored.

Configuration
REQ-027 Macro XOR_CHK_CAPTURE_EN defined: add outputs o__first_exp and o__first_act, each DATA_WIDTH wide, which latch the expected and actual values of the first mismatch after reset and hold them; cleared to 0 by either reset.
REQ-028 Macro XOR_CHK_CAPTURE_EN undefined: those ports and registers are absent; all other behaviour is identical.

Verification
REQ-029 LATENCY=1: i__en=1 with A=0x155 and B=0x0AA at t; i__dout=0x1FF at t+1 -> o__mismatch=0 at t+2, o__chk_cnt=1, o__err_cnt=0, o__state RUN.
REQ-030 LATENCY=3: A=0x3FF and B=0x001 at t; i__dout=0x3FF at t+3 -> o__mismatch pulse at t+4, o__err_cnt=1, o__state FAIL; with capture enabled, o__first_exp=0x3FE and o__first_act=0x3FF.
REQ-031 LATENCY=2: i__en pattern 1,0,1 -> exactly 2 comparisons; i__dout during the bubble slot is ignored; o__busy high from t+1 until the last compare.
REQ-032 i__sreset_n pulsed low with 2 samples in flight -> no compare occurs, counters 0, o__state IDLE, o__busy 0 on the next cycle.
REQ-033 CNT_WIDTH=4: 20 consecutive mismatching samples -> o__err_cnt and o__chk_cnt hold at 0xF.
REQ-034 i__areset_n asserted mid-stream between clock edges -> all outputs go to reset values before the next edge.
